// File: rtl/enemy_wave_scheduler.sv
// rtl/enemy_wave_scheduler.sv - enemy slot spawner/mover with hit->boom->free sequencing and pixel arbiter
module enemy_wave_scheduler #(
  parameter int NSLOT          = 4,
  parameter int SPAWN_INTERVAL = 120,
  parameter int BOOM_TICKS     = 32,
  parameter int X_RANGE        = 590,
  parameter int BOTTOM_Y       = 430
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  move_tick,
  input  logic                  enable,
  input  logic [NSLOT-1:0]      hit,
  input  logic [NSLOT-1:0]      slot_en,
  input  logic [12*NSLOT-1:0]   slot_rgb,
  output logic [10*NSLOT-1:0]   slot_x,
  output logic [10*NSLOT-1:0]   slot_y,
  output logic [NSLOT-1:0]      slot_active,
  output logic [NSLOT-1:0]      slot_boom,
  output logic                  kill_pulse,
  output logic                  escape_pulse,
  output logic [3:0]            active_count,
  output logic                  pix_en,
  output logic [11:0]           pix_rgb
);

  localparam int TW = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;
  localparam int BW = (BOOM_TICKS > 1) ? $clog2(BOOM_TICKS) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(SPAWN_INTERVAL - 1);
  localparam logic [BW-1:0] BOOM_LAST  = BW'(BOOM_TICKS - 1);
  localparam logic [9:0]    XR         = 10'(X_RANGE);
  localparam logic [9:0]    BY         = 10'(BOTTOM_Y);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACTIVE = 2'd1, S_BOOM = 2'd2} slot_state_t;

  slot_state_t     state_q [NSLOT];
  slot_state_t     state_d [NSLOT];
  logic [9:0]      x_q [NSLOT];
  logic [9:0]      x_d [NSLOT];
  logic [9:0]      y_q [NSLOT];
  logic [9:0]      y_d [NSLOT];
  logic [BW-1:0]   bc_q [NSLOT];
  logic [BW-1:0]   bc_d [NSLOT];
  logic [TW-1:0]   timer_q, timer_d;
  logic            pending_q, pending_d;
  logic [9:0]      lfsr_q, lfsr_d, spawn_x;
  logic [NSLOT-1:0] spawn_sel;
  logic            spawn_free, spawn_go, tick_en, wrap;
  logic            kill_d, escape_d;
  logic [3:0]      count_d;
  logic [NSLOT-1:0] qual;
  logic            pix_found;

  always_comb begin
    lfsr_d  = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
    spawn_x = (lfsr_q >= XR) ? lfsr_q - XR : lfsr_q;

    // Spawn target is chosen from the pre-edge state, so a slot freed this edge waits one clock.
    spawn_sel  = '0;
    spawn_free = 1'b0;
    for (int i = 0; i < NSLOT; i++) begin
      if (!spawn_free && state_q[i] == S_IDLE) begin
        spawn_sel[i] = 1'b1;
        spawn_free   = 1'b1;
      end
    end
    spawn_go = pending_q & enable & spawn_free;

    tick_en = move_tick & enable;
    wrap    = tick_en && (timer_q == TIMER_LAST);
    timer_d = timer_q;
    if (tick_en) timer_d = wrap ? '0 : timer_q + TW'(1);
    pending_d = (pending_q & ~spawn_go) | wrap;

    kill_d   = 1'b0;
    escape_d = 1'b0;
    count_d  = '0;
    for (int i = 0; i < NSLOT; i++) begin
      state_d[i] = state_q[i];
      x_d[i]     = x_q[i];
      y_d[i]     = y_q[i];
      bc_d[i]    = bc_q[i];
      case (state_q[i])
        S_IDLE: begin
          if (spawn_go && spawn_sel[i]) begin
            state_d[i] = S_ACTIVE;
            x_d[i]     = spawn_x;
            y_d[i]     = '0;
          end
        end
        S_ACTIVE: begin
          if (move_tick) begin
            if (hit[i]) begin
              state_d[i] = S_BOOM;
              bc_d[i]    = '0;
            end else if (enable) begin
              if (y_q[i] == BY) begin
                state_d[i] = S_IDLE;
                escape_d   = 1'b1;
              end else begin
                y_d[i] = y_q[i] + 10'd1;
              end
            end
          end
        end
        S_BOOM: begin
          if (move_tick) begin
            if (bc_q[i] == BOOM_LAST) begin
              state_d[i] = S_IDLE;
              kill_d     = 1'b1;
            end else begin
              bc_d[i] = bc_q[i] + BW'(1);
            end
          end
        end
        default: state_d[i] = S_IDLE;
      endcase
      count_d = count_d + {3'b000, state_d[i] != S_IDLE};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSLOT; i++) begin
        state_q[i] <= S_IDLE;
        x_q[i]     <= '0;
        y_q[i]     <= '0;
        bc_q[i]    <= '0;
      end
      timer_q      <= '0;
      pending_q    <= 1'b0;
      lfsr_q       <= 10'h2A5;
      kill_pulse   <= 1'b0;
      escape_pulse <= 1'b0;
      active_count <= '0;
    end else begin
      for (int i = 0; i < NSLOT; i++) begin
        state_q[i] <= state_d[i];
        x_q[i]     <= x_d[i];
        y_q[i]     <= y_d[i];
        bc_q[i]    <= bc_d[i];
      end
      timer_q      <= timer_d;
      pending_q    <= pending_d;
      lfsr_q       <= lfsr_d;
      kill_pulse   <= kill_d;
      escape_pulse <= escape_d;
      active_count <= count_d;
    end
  end

  for (genvar g = 0; g < NSLOT; g++) begin : g_out
    assign slot_x[10*g +: 10] = x_q[g];
    assign slot_y[10*g +: 10] = y_q[g];
    assign slot_active[g]     = (state_q[g] == S_ACTIVE);
    assign slot_boom[g]       = (state_q[g] == S_BOOM);
  end

  assign qual   = slot_en & (slot_active | slot_boom);
  assign pix_en = |qual;

  always_comb begin
    pix_rgb   = 12'hFFF;
    pix_found = 1'b0;
    for (int i = 0; i < NSLOT; i++) begin
      if (!pix_found && qual[i]) begin
        pix_rgb   = slot_rgb[12*i +: 12];
        pix_found = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_enemy_wave_scheduler.sv
// tb/tb_enemy_wave_scheduler.sv - randomized and directed checks against a behavioural slot model
module tb_enemy_wave_scheduler;
  localparam int N = 4, SI = 4, BT = 32, XR = 590, BY = 430;

  logic            clk = 1'b0;
  logic            rst = 1'b1, move_tick = 1'b0, enable = 1'b1;
  logic [N-1:0]    hit = '0, slot_en = '0;
  logic [12*N-1:0] slot_rgb = '0;
  logic [10*N-1:0] slot_x, slot_y;
  logic [N-1:0]    slot_active, slot_boom;
  logic            kill_pulse, escape_pulse, pix_en;
  logic [3:0]      active_count;
  logic [11:0]     pix_rgb;

  always #5 clk = ~clk;

  enemy_wave_scheduler #(.NSLOT(N), .SPAWN_INTERVAL(SI), .BOOM_TICKS(BT),
                         .X_RANGE(XR), .BOTTOM_Y(BY)) dut (
    .clk(clk), .rst(rst), .move_tick(move_tick), .enable(enable), .hit(hit),
    .slot_en(slot_en), .slot_rgb(slot_rgb), .slot_x(slot_x), .slot_y(slot_y),
    .slot_active(slot_active), .slot_boom(slot_boom), .kill_pulse(kill_pulse),
    .escape_pulse(escape_pulse), .active_count(active_count), .pix_en(pix_en),
    .pix_rgb(pix_rgb));

  int checks = 0, passes = 0;
  bit cmp_en = 0, rand_pix = 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // Model: 0 = idle, 1 = flying, 2 = exploding.
  int         m_st[N], m_x[N], m_y[N], m_bc[N];
  int         m_timer, m_cnt, sp, sx;
  bit         m_pend, m_kill, m_esc, wrap;
  logic [9:0] m_lfsr;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin m_st[i] = 0; m_x[i] = 0; m_y[i] = 0; m_bc[i] = 0; end
      m_timer = 0; m_pend = 0; m_lfsr = 10'h2A5; m_kill = 0; m_esc = 0; m_cnt = 0;
    end else begin
      sp = -1;
      if (m_pend && enable)
        for (int i = 0; i < N; i++) if (sp < 0 && m_st[i] == 0) sp = i;
      sx = (int'(m_lfsr) >= XR) ? int'(m_lfsr) - XR : int'(m_lfsr);
      m_kill = 0; m_esc = 0;
      if (move_tick)
        for (int i = 0; i < N; i++) begin
          if (m_st[i] == 1) begin
            if (hit[i]) begin m_st[i] = 2; m_bc[i] = 0; end
            else if (enable) begin
              if (m_y[i] == BY) begin m_st[i] = 0; m_esc = 1; end
              else m_y[i]++;
            end
          end else if (m_st[i] == 2) begin
            if (m_bc[i] == BT - 1) begin m_st[i] = 0; m_kill = 1; end
            else m_bc[i]++;
          end
        end
      if (sp >= 0) begin m_st[sp] = 1; m_x[sp] = sx; m_y[sp] = 0; end
      wrap = move_tick && enable && (m_timer == SI - 1);
      if (move_tick && enable) m_timer = wrap ? 0 : m_timer + 1;
      m_pend = (m_pend && sp < 0) || wrap;
      m_lfsr = {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
      m_cnt = 0;
      for (int i = 0; i < N; i++) if (m_st[i] != 0) m_cnt++;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic        e;
      logic [11:0] c;
      e = 0; c = 12'hFFF;
      for (int i = N - 1; i >= 0; i--)
        if (slot_en[i] && m_st[i] != 0) begin e = 1; c = slot_rgb[12*i +: 12]; end
      for (int i = 0; i < N; i++) begin
        chk("slot_x", slot_x[10*i +: 10], m_x[i]);
        chk("slot_y", slot_y[10*i +: 10], m_y[i]);
        chk("slot_active", slot_active[i], m_st[i] == 1);
        chk("slot_boom", slot_boom[i], m_st[i] == 2);
      end
      chk("kill_pulse", kill_pulse, m_kill);
      chk("escape_pulse", escape_pulse, m_esc);
      chk("active_count", active_count, m_cnt);
      chk("pix_en", pix_en, e);
      chk("pix_rgb", pix_rgb, c);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    if (rand_pix) begin
      slot_en  = N'($urandom);
      slot_rgb = {$urandom, $urandom};
    end
  endtask

  task automatic tick(input logic [N-1:0] h);
    move_tick = 1; hit = h; cyc();
    move_tick = 0; hit = '0; cyc();
  endtask

  // After reset the fourth tick raises a request; spawn x comes from the 4th LFSR successor (0x25E -> 16).
  task automatic start_run();
    rst = 1; move_tick = 0; hit = '0; enable = 1; cyc();
    cmp_en = 1;
    chk("rst_active", slot_active, 0);
    chk("rst_boom", slot_boom, 0);
    chk("rst_count", active_count, 0);
    chk("rst_kill", kill_pulse, 0);
    chk("rst_escape", escape_pulse, 0);
    rst = 0; move_tick = 1;
    repeat (4) cyc();
    chk("pre_spawn_active", slot_active, 0);
    move_tick = 0; cyc();
    chk("spawn_active", slot_active, 4'b0001);
    chk("spawn_x", slot_x[9:0], 16);
    chk("spawn_y", slot_y[9:0], 0);
    chk("spawn_count", active_count, 1);
  endtask

  initial begin
    cyc();
    start_run();
    repeat (100) tick('0);
    chk("y_after_100", slot_y[9:0], 100);
    chk("all_active", slot_active, 4'b1111);

    rand_pix = 0;
    slot_rgb = {12'hDDD, 12'hCCC, 12'hBBB, 12'hAAA};
    slot_en = 4'b0110; #1;
    chk("arb_en", pix_en, 1);
    chk("arb_rgb", pix_rgb, 12'hBBB);
    slot_en = 4'b0000; #1;
    chk("arb_none_en", pix_en, 0);
    chk("arb_none_rgb", pix_rgb, 12'hFFF);
    rand_pix = 1;

    move_tick = 1; hit = 4'b0100; cyc();
    chk("slot2_boom", slot_boom[2], 1);
    move_tick = 0; hit = '0; cyc();
    repeat (31) tick('0);
    chk("slot2_still_boom", slot_boom[2], 1);
    move_tick = 1; cyc();
    chk("slot2_kill", kill_pulse, 1);
    chk("slot2_freed", {slot_active[2], slot_boom[2]}, 2'b00);
    move_tick = 0; cyc();
    chk("slot2_respawn", slot_active[2], 1);
    chk("kill_one_clk", kill_pulse, 0);

    repeat (296) tick('0);
    chk("y_429", slot_y[9:0], 429);
    tick('0);
    chk("y_430", slot_y[9:0], 430);
    chk("y_430_active", slot_active[0], 1);
    move_tick = 1; cyc();
    chk("escape", escape_pulse, 1);
    chk("escaped_idle", slot_active[0], 0);
    move_tick = 0; cyc();
    chk("escape_one_clk", escape_pulse, 0);
    chk("slot0_respawn", slot_active[0], 1);

    start_run();
    repeat (430) tick('0);
    move_tick = 1; hit = 4'b0001; cyc();
    chk("hit_beats_escape_boom", slot_boom[0], 1);
    chk("hit_beats_escape_esc", escape_pulse, 0);
    move_tick = 0; hit = '0; cyc();
    repeat (31) tick('0);
    chk("slot0_still_boom", slot_boom[0], 1);
    move_tick = 1; cyc();
    chk("slot0_kill", kill_pulse, 1);
    chk("slot0_freed", slot_boom[0], 0);
    move_tick = 0; cyc();
    chk("kill_clear", kill_pulse, 0);

    for (int c = 0; c < 9000; c++) begin
      rst       = ($urandom_range(0, 1499) == 0);
      enable    = ((c / 200) % 5) != 4;
      move_tick = ($urandom_range(0, 2) == 0);
      hit = '0;
      if (c >= 4500)
        for (int i = 0; i < N; i++) hit[i] = ($urandom_range(0, 15) == 0);
      cyc();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
